// File: rtl/regfile_dump_tx.sv
// rtl/regfile_dump_tx.sv - walks the register bank and serialises each register as a UART frame
module regfile_dump_tx #(
    parameter int WIDTH        = 8,
    parameter int ADDR_W       = 4,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [WIDTH-1:0]  RD,
    output logic [ADDR_W-1:0] RA,
    output logic              tx,
    output logic              busy,
    output logic              done
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CLK_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_START = 3'd2,
        S_DATA  = 3'd3,
        S_STOP  = 3'd4
    } state_t;

    state_t            state, state_n;
    logic [CW-1:0]     clk_cnt, clk_cnt_n;
    logic [BW-1:0]     bit_cnt, bit_cnt_n;
    logic [WIDTH-1:0]  shift, shift_n;
    logic [ADDR_W-1:0] ra_n;
    logic              tx_n, busy_n, done_n;

    // State register: all state and the registered outputs advance together
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_IDLE;
            clk_cnt <= '0;
            bit_cnt <= '0;
            shift   <= '0;
            RA      <= '0;
            tx      <= 1'b1;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state   <= state_n;
            clk_cnt <= clk_cnt_n;
            bit_cnt <= bit_cnt_n;
            shift   <= shift_n;
            RA      <= ra_n;
            tx      <= tx_n;
            busy    <= busy_n;
            done    <= done_n;
        end
    end

    // Next-state logic: frame sequencing, bit timing and register walk
    always_comb begin
        state_n   = state;
        clk_cnt_n = clk_cnt;
        bit_cnt_n = bit_cnt;
        shift_n   = shift;
        ra_n      = RA;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_n = S_LOAD;
                    ra_n    = '0;
                end
            end
            S_LOAD: begin
                // Snapshot the register now; later regfile writes do not disturb the frame
                shift_n   = RD;
                clk_cnt_n = '0;
                bit_cnt_n = '0;
                state_n   = S_START;
            end
            S_START: begin
                if (clk_cnt == CLK_LAST) begin
                    clk_cnt_n = '0;
                    bit_cnt_n = '0;
                    state_n   = S_DATA;
                end else begin
                    clk_cnt_n = clk_cnt + CW'(1);
                end
            end
            S_DATA: begin
                if (clk_cnt == CLK_LAST) begin
                    clk_cnt_n = '0;
                    shift_n   = shift >> 1;
                    if (bit_cnt == BIT_LAST) begin
                        state_n = S_STOP;
                    end else begin
                        bit_cnt_n = bit_cnt + BW'(1);
                    end
                end else begin
                    clk_cnt_n = clk_cnt + CW'(1);
                end
            end
            S_STOP: begin
                if (clk_cnt == CLK_LAST) begin
                    clk_cnt_n = '0;
                    // Last-register test uses RA before increment so RA never wraps mid-dump
                    if (RA == {ADDR_W{1'b1}}) begin
                        state_n = S_IDLE;
                        ra_n    = '0;
                    end else begin
                        state_n = S_LOAD;
                        ra_n    = RA + ADDR_W'(1);
                    end
                end else begin
                    clk_cnt_n = clk_cnt + CW'(1);
                end
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    // Output logic: values the registered outputs take with the upcoming state
    always_comb begin
        tx_n   = 1'b1;
        busy_n = (state_n != S_IDLE);
        done_n = (state == S_STOP) && (state_n == S_IDLE);
        case (state_n)
            S_START: tx_n = 1'b0;
            S_DATA:  tx_n = shift_n[0];
            default: tx_n = 1'b1;
        endcase
    end

endmodule
